// File: rtl/layer_mac_scheduler_if.sv
// Bus bundle between the layer MAC scheduler and its weight ROM,
// activation bank, output bank and pass requester.
interface layer_mac_scheduler_if #(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_INPUTS  = 10
);
    localparam int WA_W = $clog2(NUM_NEURONS * (NUM_INPUTS + 1));
    localparam int AS_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int OA_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    logic            start;
    logic            busy;
    logic            done;
    logic [WA_W-1:0] w_addr;
    logic [15:0]     w_data;
    logic [AS_W-1:0] a_sel;
    logic [15:0]     a_data;
    logic            out_we;
    logic [OA_W-1:0] out_addr;
    logic [15:0]     out_data;

    modport master (
        input  start, w_data, a_data,
        output busy, done, w_addr, a_sel,
        output out_we, out_addr, out_data
    );

    modport slave (
        output start, w_data, a_data,
        input  busy, done, w_addr, a_sel,
        input  out_we, out_addr, out_data
    );
endinterface

// File: rtl/layer_mac_scheduler.sv
// Time-shared MAC sequencer for one dense layer with ReLU output.
// Optional macro SATURATE_EN clamps positive overflow to 16'sh7FFF.
module layer_mac_scheduler #(
    parameter int NUM_NEURONS = 10,
    parameter int NUM_INPUTS  = 10,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    layer_mac_scheduler_if.master  bus
);
    localparam int WA_W = $clog2(NUM_NEURONS * (NUM_INPUTS + 1));
    localparam int AS_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int OA_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, MAC, BIAS, WRITE, DONE
    } state_t;

    state_t state, state_nx;

    logic [AS_W-1:0] i;
    logic [OA_W-1:0] n;
    logic [WA_W-1:0] w_addr;
    logic [AS_W-1:0] a_sel, a_step;
    logic            out_we;
    logic [OA_W-1:0] out_addr;
    logic [15:0]     out_data;
    logic            last_i, last_n;

    logic signed [ACC_W-1:0] acc, acc_mac, acc_bias;
    logic signed [ACC_W-1:0] prod_x, bias_x;
    logic signed [31:0]      prod;
    logic [15:0]             r, res;

    assign last_i = (i == AS_W'(NUM_INPUTS - 1));
    assign last_n = (n == OA_W'(NUM_NEURONS - 1));
    assign a_step = last_a() ? '0 : a_sel + 1'b1;

    function automatic logic last_a();
        return a_sel == AS_W'(NUM_INPUTS - 1);
    endfunction

    assign prod     = $signed(bus.w_data) * $signed(bus.a_data);
    assign prod_x   = prod;
    assign bias_x   = $signed(bus.w_data);
    assign acc_mac  = acc + prod_x;
    assign acc_bias = acc + (bias_x <<< FRAC_BITS);
    assign r        = acc_bias[FRAC_BITS+15:FRAC_BITS];

`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_LIM =
        ACC_W'(32767) << FRAC_BITS;
    always_comb begin
        res = r;
        if (acc_bias > SAT_LIM)
            res = 16'h7FFF;
        else if (r[15])
            res = 16'h0000;
    end
`else
    assign res = r[15] ? 16'h0000 : r;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) state_nx = FETCH;
            FETCH: begin
                bus.busy = 1'b1;
                state_nx = MAC;
            end
            MAC: begin
                bus.busy = 1'b1;
                if (last_i) state_nx = BIAS;
            end
            BIAS: begin
                bus.busy = 1'b1;
                state_nx = WRITE;
            end
            WRITE: begin
                bus.busy = 1'b1;
                state_nx = last_n ? DONE : FETCH;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Addresses run one cycle ahead of the data they select.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            i        <= '0;
            n        <= '0;
            w_addr   <= '0;
            a_sel    <= '0;
            out_we   <= 1'b0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            out_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        n      <= '0;
                        w_addr <= '0;
                        a_sel  <= '0;
                    end
                end
                FETCH: begin
                    acc    <= '0;
                    i      <= '0;
                    w_addr <= w_addr + 1'b1;
                    a_sel  <= a_step;
                end
                MAC: begin
                    acc <= acc_mac;
                    i   <= i + 1'b1;
                    if (!last_i) begin
                        w_addr <= w_addr + 1'b1;
                        a_sel  <= a_step;
                    end
                end
                BIAS: begin
                    acc      <= acc_bias;
                    out_we   <= 1'b1;
                    out_addr <= n;
                    out_data <= res;
                end
                WRITE: begin
                    a_sel <= '0;
                    if (last_n) begin
                        w_addr <= '0;
                    end else begin
                        n      <= n + 1'b1;
                        w_addr <= w_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.w_addr   = w_addr;
    assign bus.a_sel    = a_sel;
    assign bus.out_we   = out_we;
    assign bus.out_addr = out_addr;
    assign bus.out_data = out_data;
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Directed bench for layer_mac_scheduler with a ROM model and an
// expected-write queue checked at every output-bank strobe.
module tb_layer_mac_scheduler;
  localparam int NN = 10;
  localparam int NI = 10;
  localparam int FR = 8;
  localparam int ROMN = NN * (NI + 1);

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  logic [15:0] rom [0:ROMN-1];
  logic [15:0] act [0:NI-1];

  layer_mac_scheduler_if #(
    .NUM_NEURONS(NN),
    .NUM_INPUTS(NI)
  ) bus();

  layer_mac_scheduler #(
    .NUM_NEURONS(NN),
    .NUM_INPUTS(NI),
    .FRAC_BITS(FR),
    .ACC_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.w_data <= rom[int'(bus.w_addr)];
    bus.a_data <= act[int'(bus.a_sel)];
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, expv);
    end
  endtask

  task automatic fill(input logic [15:0] w,
                      input logic [15:0] a,
                      input bit ramp,
                      input logic [15:0] b);
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++)
        rom[n*(NI+1)+i] = w;
      rom[n*(NI+1)+NI] = ramp ? 16'(n * 16) : b;
    end
    for (int i = 0; i < NI; i++)
      act[i] = a;
  endtask

  function automatic logic [15:0] golden(input int n);
    longint s;
    logic [31:0] acc;
    logic [15:0] r;
    s = 0;
    for (int i = 0; i < NI; i++)
      s += longint'($signed(rom[n*(NI+1)+i]))
         * longint'($signed(act[i]));
    s += longint'($signed(rom[n*(NI+1)+NI]))
       * (1 << FR);
    acc = s[31:0];
    r = acc[FR+15:FR];
`ifdef SATURATE_EN
    if ($signed(acc) > 32767 * (1 << FR))
      return 16'h7FFF;
`endif
    return r[15] ? 16'h0000 : r;
  endfunction

  task automatic push_const(input logic [15:0] d);
    for (int n = 0; n < NN; n++)
      exp_q.push_back('{a: 4'(n), d: d});
  endtask

  task automatic push_golden();
    for (int n = 0; n < NN; n++)
      exp_q.push_back('{a: 4'(n), d: golden(n)});
  endtask

  task automatic run_pass(input bit extra);
    int   cyc;
    int   writes;
    int   done_cyc;
    int   last_wr;
    bit   got_done;
    bit   stray;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    writes = 0;
    done_cyc = 0;
    last_wr = 0;
    got_done = 1'b0;
    chk("busy_rise", bus.busy, 1'b1);
    while (!got_done && cyc < 1000) begin
      if (bus.out_we) begin
        writes++;
        last_wr = cyc;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_addr", bus.out_addr, e.a);
          chk("out_data", bus.out_data, e.d);
        end else begin
          chk("extra_write", bus.out_we, 1'b0);
        end
      end
      if (bus.done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        chk("busy_at_done", bus.busy, 1'b0);
      end
      bus.start = extra && (cyc == 50 || got_done);
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen", got_done, 1'b1);
    chk("done_cycle", done_cyc, NN*(NI+3)+1);
    chk("last_write_cycle", last_wr, NN*(NI+3));
    chk("write_count", writes, NN);
    chk("queue_empty", exp_q.size(), 0);
    @(negedge clk);
    bus.start = 1'b0;
    stray = 1'b0;
    repeat (4) begin
      stray |= bus.busy | bus.done | bus.out_we;
      @(negedge clk);
    end
    chk("idle_after_pass", stray, 1'b0);
  endtask

  initial begin
    bit stray;
    reset = 1'b1;
    bus.start = 1'b0;
    fill(16'h0000, 16'h0000, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_out_we", bus.out_we, 1'b0);
    chk("rst_out_addr", bus.out_addr, 4'd0);
    chk("rst_out_data", bus.out_data, 16'h0000);
    chk("rst_w_addr", bus.w_addr, 7'd0);
    chk("rst_a_sel", bus.a_sel, 4'd0);
    reset = 1'b0;

    fill(16'h0100, 16'h0100, 1'b0, 16'h0000);
    push_const(16'h0A00);
    run_pass(1'b0);

    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (55) @(negedge clk);
    chk("mid_busy", bus.busy, 1'b1);
    chk("mid_last_addr", bus.out_addr, 4'd3);
    reset = 1'b1;
    stray = 1'b0;
    repeat (3) begin
      @(negedge clk);
      stray |= bus.out_we | bus.done;
    end
    reset = 1'b0;
    chk("rst_mid_stray", stray, 1'b0);
    chk("rst_mid_busy", bus.busy, 1'b0);
    chk("rst_mid_out_addr", bus.out_addr, 4'd0);
    chk("rst_mid_out_data", bus.out_data, 16'h0000);
    chk("rst_mid_w_addr", bus.w_addr, 7'd0);
    stray = 1'b0;
    repeat (5) begin
      @(negedge clk);
      stray |= bus.out_we | bus.done | bus.busy;
    end
    chk("rst_mid_quiet", stray, 1'b0);
    push_const(16'h0A00);
    run_pass(1'b0);

    fill(16'hFF00, 16'h0100, 1'b0, 16'h0080);
    push_const(16'h0000);
    run_pass(1'b0);

    fill(16'h0000, 16'h0100, 1'b1, 16'h0000);
    for (int n = 0; n < NN; n++)
      exp_q.push_back('{a: 4'(n), d: 16'(n * 16)});
    run_pass(1'b0);

    for (int n = 0; n < NN; n++)
      exp_q.push_back('{a: 4'(n), d: 16'(n * 16)});
    run_pass(1'b1);

    fill(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000);
    push_golden();
    run_pass(1'b0);

    for (int k = 0; k < ROMN; k++)
      rom[k] = 16'($signed($urandom_range(0, 1023)) - 512);
    for (int i = 0; i < NI; i++)
      act[i] = 16'($signed($urandom_range(0, 1023)) - 512);
    push_golden();
    run_pass(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
